// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-mux select controller.
package clk_switch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_e;

    // $clog2 that never returns zero, so single-entry ranges still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // One counter serves both the settle and the dwell window.
    function automatic int unsigned cnt_width(input int unsigned settle,
                                              input int unsigned dwell);
        int unsigned a;
        int unsigned b;
        a = clog2_min1(settle);
        b = clog2_min1(dwell + 1);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr.
module rr_arbiter
    import clk_switch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand      = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
        grant_oh = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences the glitch-free clock mux select for several requesters:
// round-robin grant, settle window after each sel change, then a dwell hold-off.
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DWELL_CYCLES  = 16,
    parameter bit          RESET_SEL     = 1'b0,
    localparam int unsigned IDX_W        = clog2_min1(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_sel_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               sel_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [IDX_W-1:0]   grant_id_o
);

    localparam int unsigned CNT_W       = cnt_width(SETTLE_CYCLES, DWELL_CYCLES);
    localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned DWELL_LOAD  = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sel_q;
    logic               busy_q;
    logic               done_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   ptr_q;

    logic [NUM_REQ-1:0] req_masked_c;
    logic [NUM_REQ-1:0] grant_oh_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               any_grant_c;
    logic [IDX_W-1:0]   next_ptr_c;

    // A request acknowledged this cycle completes on this edge; never re-grant it.
    assign req_masked_c = req_valid_i & ~ready_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_masked_c),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh_c),
        .grant_idx (grant_idx_c),
        .any_grant (any_grant_c)
    );

    assign next_ptr_c = (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0
                                                             : grant_idx_c + IDX_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= RESET_SEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            ready_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_grant_c) begin
                        grant_q <= grant_idx_c;
                        ptr_q   <= next_ptr_c;
                        if (req_sel_i[grant_idx_c] == sel_q) begin
                            // Already on the requested clock: ack without touching the mux.
                            ready_q <= grant_oh_c;
                            done_q  <= 1'b1;
                        end else begin
                            sel_q   <= req_sel_i[grant_idx_c];
                            cnt_q   <= CNT_W'(SETTLE_LOAD);
                            busy_q  <= 1'b1;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        ready_q <= NUM_REQ'(1) << grant_q;
                        done_q  <= 1'b1;
                        if (DWELL_CYCLES == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= CNT_W'(DWELL_LOAD);
                            state_q <= ST_DWELL;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DWELL: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign grant_id_o  = grant_q;

    // Single acknowledge per cycle, and done mirrors it.
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ready_q) && (done_q == (|ready_q)));

    // The mux select may only move on the IDLE->SETTLE transition.
    a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != ST_IDLE) |=> $stable(sel_q));

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: vector table, directed corner sequences,
// and random request rounds against a transaction-level timing model.
module tb_clk_switch_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned S   = 8;
    localparam int unsigned D   = 16;
    localparam int unsigned IW  = 2;
    localparam int          LEN = 512;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_sel = '0;
    logic [N-1:0]  req_ready;
    logic          sel;
    logic          busy;
    logic          done;
    logic [IW-1:0] gid;

    clk_switch_ctrl #(
        .NUM_REQ       (N),
        .SETTLE_CYCLES (S),
        .DWELL_CYCLES  (D),
        .RESET_SEL     (1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_sel_i   (req_sel),
        .req_ready_o (req_ready),
        .sel_o       (sel),
        .busy_o      (busy),
        .done_o      (done),
        .grant_id_o  (gid)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    int   m_gid = 0;
    logic m_sel = 1'b0;

    logic [N-1:0] e_rdy  [LEN];
    logic         e_sel  [LEN];
    logic         e_busy [LEN];
    int           e_gid  [LEN];

    typedef struct {
        int   id;
        logic rsel;
        int   lat;
        int   busy_n;
        int   toggles;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_pack();
        return 32'({req_ready, done, sel, busy, gid});
    endfunction

    task automatic do_reset();
        rst_i     = 1'b1;
        req_valid = '0;
        step();
        step();
        rst_i = 1'b0;
        m_ptr = 0;
        m_gid = 0;
        m_sel = 1'b0;
    endtask

    // Model: a grant at arbitration edge t acks at t+1 (same sel) or t+S+1 (switch);
    // the next arbitration happens D edges after a switch ack, immediately after a same-sel ack.
    task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] sels, input string tag);
        logic [N-1:0] pend;
        logic [N-1:0] drop;
        logic [31:0]  exp;
        int           t;
        int           g;
        int           ack;
        for (int k = 0; k < LEN; k++) begin
            e_rdy[k]  = '0;
            e_sel[k]  = m_sel;
            e_busy[k] = 1'b0;
            e_gid[k]  = m_gid;
        end
        pend = mask;
        t    = 0;
        while (pend != '0) begin
            g = -1;
            for (int i = 0; i < int'(N); i++) begin
                int c;
                c = (m_ptr + i) % int'(N);
                if (g < 0 && pend[c]) g = c;
            end
            pend[g] = 1'b0;
            m_ptr   = (g + 1) % int'(N);
            m_gid   = g;
            for (int k = t + 1; k < LEN; k++) e_gid[k] = g;
            if (sels[g] == m_sel) begin
                ack = t + 1;
                t   = ack;
            end else begin
                ack   = t + int'(S) + 1;
                m_sel = sels[g];
                for (int k = t + 1; k < LEN; k++) e_sel[k] = m_sel;
                for (int k = t + 1; k <= t + int'(S + D); k++) e_busy[k] = 1'b1;
                t = ack + int'(D);
            end
            e_rdy[ack][g] = 1'b1;
        end
        req_sel   = sels;
        req_valid = mask;
        drop      = '0;
        for (int k = 1; k <= t + 2; k++) begin
            step();
            exp = 32'({e_rdy[k], |e_rdy[k], e_sel[k], e_busy[k], IW'(e_gid[k])});
            check($sformatf("%s cyc%0d {rdy,done,sel,busy,gid}", tag, k), act_pack(), exp);
            req_valid = req_valid & ~drop;
            drop      = req_ready;
        end
        req_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   busy_n;
        int   tog;
        int   guard;
        int   n_ack;
        int   last_ack;
        int   cyc;
        logic prev;
        logic k1_sel;
        logic got;
        logic saw_done;
        logic [N-1:0] exp_oh;

        tbl[0] = '{id: 2, rsel: 1'b1, lat: 9, busy_n: 24, toggles: 1};
        tbl[1] = '{id: 1, rsel: 1'b1, lat: 1, busy_n: 0,  toggles: 0};
        tbl[2] = '{id: 1, rsel: 1'b0, lat: 9, busy_n: 24, toggles: 1};
        tbl[3] = '{id: 1, rsel: 1'b0, lat: 1, busy_n: 0,  toggles: 0};
        tbl[4] = '{id: 0, rsel: 1'b1, lat: 9, busy_n: 24, toggles: 1};
        tbl[5] = '{id: 3, rsel: 1'b1, lat: 1, busy_n: 0,  toggles: 0};
        tbl[6] = '{id: 3, rsel: 1'b0, lat: 9, busy_n: 24, toggles: 1};

        do_reset();
        check("reset_state {rdy,done,sel,busy,gid}", act_pack(), 32'h0);

        foreach (tbl[r]) begin
            req_sel             = '0;
            req_sel[tbl[r].id]  = tbl[r].rsel;
            req_valid           = '0;
            req_valid[tbl[r].id] = 1'b1;
            lat = 0; busy_n = 0; tog = 0; prev = sel; k1_sel = 1'bx; got = 1'b0;
            while (!got && lat < 100) begin
                step();
                lat++;
                if (busy) busy_n++;
                if (sel !== prev) tog++;
                prev = sel;
                if (lat == 1) k1_sel = sel;
                if (req_ready != '0) got = 1'b1;
            end
            exp_oh = N'(1) << tbl[r].id;
            check($sformatf("row%0d latency", r), 32'(lat), 32'(tbl[r].lat));
            check($sformatf("row%0d ready", r), 32'(req_ready), 32'(exp_oh));
            check($sformatf("row%0d done", r), 32'(done), 32'h1);
            check($sformatf("row%0d grant_id", r), 32'(gid), 32'(tbl[r].id));
            check($sformatf("row%0d sel_after_1", r), 32'(k1_sel), 32'(tbl[r].rsel));
            step();
            if (busy) busy_n++;
            if (sel !== prev) tog++;
            prev = sel;
            check($sformatf("row%0d ready_one_cycle", r), 32'({req_ready, done}), 32'h0);
            req_valid = '0;
            guard = 0;
            while (busy && guard < 100) begin
                step();
                if (busy) busy_n++;
                if (sel !== prev) tog++;
                prev = sel;
                guard++;
            end
            check($sformatf("row%0d busy_cycles", r), 32'(busy_n), 32'(tbl[r].busy_n));
            check($sformatf("row%0d sel_toggles", r), 32'(tog), 32'(tbl[r].toggles));
            m_gid = tbl[r].id;
            m_ptr = (tbl[r].id + 1) % int'(N);
            m_sel = tbl[r].rsel;
        end

        // All four at once with alternating selects, pointer at 0.
        run_round(4'b1111, 4'b1010, "all4");

        // Requester 3 held continuously, requester 0 re-requesting: must alternate.
        do_reset();
        req_sel   = 4'b0001;
        req_valid = 4'b1001;
        n_ack = 0; cyc = 0; last_ack = 0;
        while (n_ack < 6 && cyc < 400) begin
            step();
            cyc++;
            if (req_ready != '0) begin
                exp_oh = (n_ack % 2 == 0) ? 4'b0001 : 4'b1000;
                check($sformatf("alt ack%0d ready", n_ack), 32'(req_ready), 32'(exp_oh));
                if (n_ack > 0)
                    check($sformatf("alt ack%0d spacing", n_ack), 32'(cyc - last_ack), 32'(S + D + 1));
                last_ack = cyc;
                n_ack++;
            end
        end
        check("alt ack_count", 32'(n_ack), 32'd6);
        step();
        req_valid = '0;
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        check("alt idle_after", 32'(busy), 32'h0);

        // Reset in the middle of a settle window.
        do_reset();
        req_sel   = 4'b0010;
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) step();
        check("midsettle pre {sel,busy}", 32'({sel, busy}), 32'h3);
        rst_i = 1'b1;
        step();
        check("midsettle post_reset {rdy,done,sel,busy,gid}", act_pack(), 32'h0);
        rst_i     = 1'b0;
        req_valid = '0;
        m_ptr = 0; m_gid = 0; m_sel = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("midsettle no_done", 32'(saw_done), 32'h0);
        run_round(4'b1010, 4'b0000, "post_reset");

        // Random request rounds.
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] mask;
            logic [N-1:0] sels;
            mask = N'($urandom_range(1, (1 << N) - 1));
            sels = N'($urandom);
            run_round(mask, sels, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Controller that sequences the glitch-free clock mux select line on behalf of several requesters.
- Arbitrates switch requests round-robin and drives the mux select.
- Counts a settle window that covers the mux's synchroniser stages on both clock domains, then enforces a minimum dwell time before the next switch.
- Runs on one always-on controller clock and sits beside the clock mux in the clock/reset subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (≥1).
- SETTLE_CYCLES, 8, controller cycles to wait after a sel change; must cover 2×SYNC_STAGES of the slowest mux input clock.
- DWELL_CYCLES, 16, minimum controller cycles between completion of one switch and the start of the next (≥0).
- RESET_SEL, 0, select value driven out of reset.

Ports:
- clk_i  in  1  controller clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester switch request.
- req_sel_i  in  NUM_REQ  requested select per requester (bit k belongs to requester k).
- req_ready_o  out  NUM_REQ  one-hot acknowledge; a request completes on valid&ready.
- sel_o  out  1  select line to the clock mux.
- busy_o  out  1  high in SETTLE and DWELL.
- done_o  out  1  one-cycle pulse when a switch has settled.
- grant_id_o  out  $clog2(NUM_REQ) (min 1)  index of the last granted requester.

Behaviour:
- Reset (sync, rst_i high at posedge):
  - sel_o=RESET_SEL; busy_o=0; done_o=0; req_ready_o=0; grant_id_o=0.
  - Round-robin pointer=0; state=IDLE; counters=0.
  - Reset mid-SETTLE or mid-DWELL aborts immediately. sel_o returns to RESET_SEL and no done_o is issued.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - If any req_valid_i is set, grant the lowest index at or after the pointer, wrapping modulo NUM_REQ, combinationally.
  - On the next posedge, latch grant_id_o and advance the pointer to grant+1 (wrapping).
  - If req_sel_i[grant]==sel_o: pulse req_ready_o[grant] and done_o in that cycle (registered), stay in IDLE. No settle, no dwell.
  - Else: load sel_o=req_sel_i[grant], load the counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When it reaches 0, pulse req_ready_o[grant] and done_o for one cycle and load the dwell counter.
  - Go to DWELL, or to IDLE if DWELL_CYCLES==0.
  - sel_o changes exactly once per switch.
- DWELL: count DWELL_CYCLES cycles, then go to IDLE. Requests are held off (ready low).
- Handshake:
  - The requester must hold valid and sel stable until it sees ready.
  - A valid that drops before ready is not an error. If that requester is the current grant in SETTLE, the switch still completes and the ack pulse is simply unobserved.
- Latency:
  - Switch request to done_o: SETTLE_CYCLES+1 cycles.
  - Back-to-back switch acks: at least SETTLE_CYCLES+DWELL_CYCLES+1 cycles apart.
- Simultaneous requests: exactly one grant per arbitration. The others wait; the pointer guarantees each requester is served within NUM_REQ grants.
- At most one bit of req_ready_o is high in any cycle. done_o is high iff some ready bit is high.

Decomposition:
- Package clk_switch_ctrl_pkg holds:
  - the state enum (IDLE, SETTLE, DWELL);
  - a counter width function max($clog2(SETTLE_CYCLES), $clog2(DWELL_CYCLES+1)).
- One sub-module, rr_arbiter, is natural. It is combinational, with a registered pointer input. Inputs: req vector and pointer. Outputs: grant one-hot, grant index, any_grant.

Test Plan:
- Reset, then requester 2 asks sel=1 with SETTLE=8, DWELL=16:
  - sel_o rises 1 cycle after valid.
  - ready[2] and done_o pulse exactly 9 cycles after valid.
  - busy_o stays high for 8+16 cycles.
- Requester 1 asks sel=0 while sel_o=0: ready[1] pulses on the cycle after valid, busy_o stays 0, sel_o never toggles.
- All 4 requesters valid with alternating sel (0,1,0,1) from pointer 0:
  - Grants arrive in order 0,1,2,3.
  - Each differing switch is separated by ≥25 cycles.
  - No two ready bits are ever high together.
- Requester 3 held valid continuously while requester 0 re-requests after each ack: grants alternate 0,3,0,3 with no starvation.
- rst_i asserted mid-SETTLE (cycle 4 of 8) after switching to sel=1:
  - Next cycle sel_o=0, busy_o=0, state IDLE.
  - No done_o pulse.
  - A fresh request is re-served from pointer 0.
- Hook sel_o to a clk_mux with input clocks 5ns/7ns half-periods, run random requests for 0.5ms: the mux output glitch monitor reports no errors, and the clock matching checks pass after each done_o.
